mem_responder: RTL and testbench

Serial-link memory-side responder: the far end of the core's 2-bit-per-cycle command/data link. It deserializes command frames (start symbol, command, 16-bit address, optional write data), performs one access on a simple synchronous memory port, and serializes 16-bit read responses back, each preceded by a start symbol. It sits outside the CPU core, as a RAM emulator for simulation/FPGA, and mirrors the core's prefetch/load transmit and receive paths.

---
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - serial-link memory-side responder: command deserializer, memory port, response serializer
module mem_responder #(
   parameter int                 IO_BITS        = 2,
   parameter int                 PAYLOAD_CYCLES = 8,
   parameter int                 RESP_DELAY     = 1,
   parameter logic [IO_BITS-1:0] START_SYMBOL   = 2'b01
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IO_BITS-1:0] rx_pins,
   output logic [IO_BITS-1:0] tx_pins,
   output logic [15:0]        mem_addr,
   output logic               mem_re,
   input  logic [15:0]        mem_rdata,
   output logic               mem_we,
   output logic [15:0]        mem_wdata,
   output logic [1:0]         mem_wmask,
   output logic               rx_busy,
   output logic               tx_busy,
   output logic               overflow,
   output logic               bad_cmd
);
   localparam int            CW        = $clog2(PAYLOAD_CYCLES);
   localparam logic [CW-1:0] LAST_FULL = CW'(PAYLOAD_CYCLES - 1);
   localparam logic [CW-1:0] LAST_HALF = CW'(PAYLOAD_CYCLES / 2 - 1);
   localparam logic [3:0]    WAIT_LAST = 4'(RESP_DELAY == 0 ? 0 : RESP_DELAY - 1);

   localparam logic [1:0] CMD_READ16  = 2'b00;
   localparam logic [1:0] CMD_WRITE16 = 2'b01;
   localparam logic [1:0] CMD_WRITE8  = 2'b10;
   localparam logic [1:0] CMD_RSVD    = 2'b11;

   typedef enum logic [1:0] {RX_IDLE, RX_CMD, RX_ADDR, RX_DATA} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_START, TX_PAYLOAD} tx_state_t;
   localparam tx_state_t TX_FIRST = (RESP_DELAY == 0) ? TX_START : TX_WAIT;

   rx_state_t     rx_state, rx_next;
   logic [CW-1:0] rx_cnt;
   logic          armed;
   logic [1:0]    cmd;
   logic [15:0]   addr_sr, data_sr, addr_next, data_next;
   logic          rx_data_last;

   // Payloads arrive LSB pair first, so shift in from the top.
   assign addr_next    = {rx_pins, addr_sr[15:IO_BITS]};
   assign data_next    = {rx_pins, data_sr[15:IO_BITS]};
   assign rx_data_last = (rx_cnt == ((cmd == CMD_WRITE8) ? LAST_HALF : LAST_FULL));

   always_ff @(posedge clk) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE: if (armed && rx_pins[0]) rx_next = RX_CMD;
         RX_CMD:  rx_next = RX_ADDR;
         RX_ADDR: if (rx_cnt == LAST_FULL)
                     rx_next = (cmd == CMD_WRITE16 || cmd == CMD_WRITE8) ? RX_DATA : RX_IDLE;
         RX_DATA: if (rx_data_last) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_cnt    <= '0;
         armed     <= 1'b0;
         cmd       <= '0;
         addr_sr   <= '0;
         data_sr   <= '0;
         mem_addr  <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         rx_busy   <= 1'b0;
         bad_cmd   <= 1'b0;
      end else begin
         mem_re  <= 1'b0;
         mem_we  <= 1'b0;
         rx_busy <= (rx_next != RX_IDLE);
         rx_cnt  <= (rx_next == rx_state) ? rx_cnt + 1'b1 : '0;
         if (rx_pins == '0) armed <= 1'b1;
         case (rx_state)
            RX_CMD: begin
               cmd <= rx_pins[1:0];
               if (rx_pins[1:0] == CMD_RSVD) bad_cmd <= 1'b1;
            end
            RX_ADDR: begin
               addr_sr <= addr_next;
               if (rx_cnt == LAST_FULL && cmd == CMD_READ16) begin
                  mem_re   <= 1'b1;
                  mem_addr <= addr_next;
               end
            end
            RX_DATA: begin
               data_sr <= data_next;
               if (rx_data_last) begin
                  mem_we   <= 1'b1;
                  mem_addr <= addr_sr;
                  if (cmd == CMD_WRITE8) begin
                     mem_wdata <= {data_next[15:8], data_next[15:8]};
                     mem_wmask <= addr_sr[0] ? 2'b10 : 2'b01;
                  end else begin
                     mem_wdata <= data_next;
                     mem_wmask <= 2'b11;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   tx_state_t     tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    wait_cnt;
   logic [15:0]   shreg, pend_data;
   logic          pend_valid, capture, have_data, tx_done, tx_load;

   // A capture arriving while the transmitter takes new data bypasses the pending slot.
   assign have_data = pend_valid || capture;
   assign tx_done   = (tx_state == TX_PAYLOAD) && (tx_cnt == LAST_FULL);
   assign tx_load   = have_data && ((tx_state == TX_IDLE) || tx_done);

   always_ff @(posedge clk) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:    if (have_data) tx_next = TX_FIRST;
         TX_WAIT:    if (wait_cnt == WAIT_LAST) tx_next = TX_START;
         TX_START:   tx_next = TX_PAYLOAD;
         TX_PAYLOAD: if (tx_cnt == LAST_FULL) tx_next = have_data ? TX_FIRST : TX_IDLE;
         default:    tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         capture    <= 1'b0;
         tx_cnt     <= '0;
         wait_cnt   <= '0;
         shreg      <= '0;
         pend_data  <= '0;
         pend_valid <= 1'b0;
         overflow   <= 1'b0;
         tx_busy    <= 1'b0;
         tx_pins    <= '0;
      end else begin
         capture  <= mem_re;
         tx_busy  <= (tx_next != TX_IDLE);
         wait_cnt <= (tx_state == TX_WAIT) ? wait_cnt + 1'b1 : '0;
         tx_cnt   <= (tx_state == TX_PAYLOAD) ? tx_cnt + 1'b1 : '0;
         if (tx_load) begin
            shreg      <= pend_valid ? pend_data : mem_rdata;
            pend_valid <= pend_valid && capture;
            if (capture) pend_data <= mem_rdata;
         end else begin
            if (tx_state == TX_PAYLOAD) shreg <= shreg >> IO_BITS;
            if (capture) begin
               if (pend_valid) begin
                  overflow <= 1'b1;
               end else begin
                  pend_valid <= 1'b1;
                  pend_data  <= mem_rdata;
               end
            end
         end
         // Output is registered from the next state, so tx_pins tracks tx_state cycle for cycle.
         case (tx_next)
            TX_START:   tx_pins <= START_SYMBOL;
            TX_PAYLOAD: tx_pins <= (tx_state == TX_START) ? shreg[IO_BITS-1:0]
                                                          : shreg[2*IO_BITS-1:IO_BITS];
            default:    tx_pins <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven bench for mem_responder at RESP_DELAY 1, 0 and 12
module tb_mem_responder;
   localparam int MAXC = 80;
   localparam int NI   = 3;
   localparam int S    = 2;

   logic        clk     = 1'b0;
   logic        reset   = 1'b1;
   logic [1:0]  rx_pins = 2'b00;
   logic [1:0]  tx_a    [NI];
   logic [15:0] addr_a  [NI];
   logic [15:0] wdata_a [NI];
   logic [15:0] rdata_a [NI];
   logic [1:0]  wm_a    [NI];
   logic        re_a    [NI];
   logic        we_a    [NI];
   logic        rxb_a   [NI];
   logic        txb_a   [NI];
   logic        ov_a    [NI];
   logic        bad_a   [NI];

   logic [1:0]  l_tx   [NI][MAXC];
   logic [1:0]  e_tx   [NI][MAXC];
   logic [15:0] l_addr [NI][MAXC];
   logic [15:0] l_wd   [NI][MAXC];
   logic [1:0]  l_wm   [NI][MAXC];
   logic        l_re   [NI][MAXC];
   logic        l_we   [NI][MAXC];
   logic        l_rxb  [NI][MAXC];
   logic        l_txb  [NI][MAXC];
   logic        l_ov   [NI][MAXC];
   logic        l_bad  [NI][MAXC];
   logic [1:0]  stim   [$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_model(input logic [15:0] a);
      return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5AC3);
   endfunction

   function automatic int dly(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 0 : 12);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_responder #(.RESP_DELAY(g == 0 ? 1 : (g == 1 ? 0 : 12))) u_dut (
         .clk      (clk),
         .reset    (reset),
         .rx_pins  (rx_pins),
         .tx_pins  (tx_a[g]),
         .mem_addr (addr_a[g]),
         .mem_re   (re_a[g]),
         .mem_rdata(rdata_a[g]),
         .mem_we   (we_a[g]),
         .mem_wdata(wdata_a[g]),
         .mem_wmask(wm_a[g]),
         .rx_busy  (rxb_a[g]),
         .tx_busy  (txb_a[g]),
         .overflow (ov_a[g]),
         .bad_cmd  (bad_a[g])
      );
   end

   always @(posedge clk)
      for (int g = 0; g < NI; g++)
         if (re_a[g]) rdata_a[g] <= mem_model(addr_a[g]);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_frame(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
      stim.push_back(2'b01);
      stim.push_back(c);
      for (int i = 0; i < 8; i++) stim.push_back(a[2*i +: 2]);
      if (c == 2'b01) for (int i = 0; i < 8; i++) stim.push_back(d[2*i +: 2]);
      if (c == 2'b10) for (int i = 0; i < 4; i++) stim.push_back(d[2*i +: 2]);
   endtask

   task automatic clear_exp();
      for (int g = 0; g < NI; g++)
         for (int t = 0; t < MAXC; t++) e_tx[g][t] = 2'b00;
   endtask

   task automatic add_resp(input int g, input int st, input logic [15:0] v);
      e_tx[g][st] = 2'b01;
      for (int k = 0; k < 8; k++) e_tx[g][st+1+k] = v[2*k +: 2];
   endtask

   task automatic run(input int n, input int rst_lo, input int rst_hi);
      for (int t = 0; t < n; t++) begin
         rx_pins = (t < stim.size()) ? stim[t] : 2'b00;
         reset   = (t >= rst_lo) && (t < rst_hi);
         for (int g = 0; g < NI; g++) begin
            l_tx[g][t]   = tx_a[g];
            l_addr[g][t] = addr_a[g];
            l_wd[g][t]   = wdata_a[g];
            l_wm[g][t]   = wm_a[g];
            l_re[g][t]   = re_a[g];
            l_we[g][t]   = we_a[g];
            l_rxb[g][t]  = rxb_a[g];
            l_txb[g][t]  = txb_a[g];
            l_ov[g][t]   = ov_a[g];
            l_bad[g][t]  = bad_a[g];
         end
         @(posedge clk);
         #1;
      end
      rx_pins = 2'b00;
      reset   = 1'b0;
   endtask

   task automatic chk_tx(input string nm, input int n);
      int bad_t;
      for (int g = 0; g < NI; g++) begin
         bad_t = -1;
         for (int t = n - 1; t >= 0; t--)
            if (l_tx[g][t] !== e_tx[g][t]) bad_t = t;
         n_cmp++;
         if (bad_t >= 0) begin
            n_bad++;
            $display("FAIL %s_tx_g%0d: cycle %0d got %b want %b", nm, g, bad_t,
                     l_tx[g][bad_t], e_tx[g][bad_t]);
         end
      end
   endtask

   task automatic chk_strobes(input int g, input string nm, input int n, input int re_c,
                              input int we_c, input logic [15:0] ea, input logic [15:0] ewd,
                              input logic [1:0] ewm);
      int re_n, we_n, re_t, we_t;
      re_n = 0; we_n = 0; re_t = -1; we_t = -1;
      for (int t = 0; t < n; t++) begin
         if (l_re[g][t]) begin re_n++; re_t = t; end
         if (l_we[g][t]) begin we_n++; we_t = t; end
      end
      chk($sformatf("%s_g%0d_re_cnt", nm, g), re_n, (re_c >= 0) ? 1 : 0);
      chk($sformatf("%s_g%0d_we_cnt", nm, g), we_n, (we_c >= 0) ? 1 : 0);
      if (re_c >= 0 && re_t >= 0) begin
         chk($sformatf("%s_g%0d_re_cycle", nm, g), re_t, re_c);
         chk($sformatf("%s_g%0d_re_addr", nm, g), l_addr[g][re_t], ea);
      end
      if (we_c >= 0 && we_t >= 0) begin
         chk($sformatf("%s_g%0d_we_cycle", nm, g), we_t, we_c);
         chk($sformatf("%s_g%0d_we_addr", nm, g), l_addr[g][we_t], ea);
         chk($sformatf("%s_g%0d_wdata", nm, g), l_wd[g][we_t], ewd);
         chk($sformatf("%s_g%0d_wmask", nm, g), l_wm[g][we_t], ewm);
      end
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [15:0] addr;
      logic [15:0] data;
      int          re_off;
      int          we_off;
      logic [15:0] ewd;
      logic [1:0]  ewm;
   } vec_t;

   vec_t vt [7];

   initial begin
      vt[0] = '{2'b00, 16'h1234, 16'h0000, 10, -1, 16'h0000, 2'b00};
      vt[1] = '{2'b01, 16'h0010, 16'hA5C3, -1, 18, 16'hA5C3, 2'b11};
      vt[2] = '{2'b10, 16'h0021, 16'h007E, -1, 14, 16'h7E7E, 2'b10};
      vt[3] = '{2'b10, 16'h0020, 16'h007E, -1, 14, 16'h7E7E, 2'b01};
      vt[4] = '{2'b00, 16'hF00D, 16'h0000, 10, -1, 16'h0000, 2'b00};
      vt[5] = '{2'b01, 16'hFFFF, 16'h8001, -1, 18, 16'h8001, 2'b11};
      vt[6] = '{2'b10, 16'h0003, 16'hFFC5, -1, 14, 16'hC5C5, 2'b10};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++)
         chk($sformatf("reset_outputs_g%0d", g),
             {tx_a[g], re_a[g], we_a[g], addr_a[g], wdata_a[g], wm_a[g],
              rxb_a[g], txb_a[g], ov_a[g], bad_a[g]}, 64'd0);

      for (int i = 0; i < 7; i++) begin
         stim.delete();
         stim.push_back(2'b00);
         stim.push_back(2'b00);
         push_frame(vt[i].cmd, vt[i].addr, vt[i].data);
         clear_exp();
         if (vt[i].cmd == 2'b00)
            for (int g = 0; g < NI; g++) add_resp(g, S + 12 + dly(g), mem_model(vt[i].addr));
         run(40, -1, -1);
         chk_tx($sformatf("v%0d", i), 40);
         for (int g = 0; g < NI; g++)
            chk_strobes(g, $sformatf("v%0d", i), 40,
                        (vt[i].re_off >= 0) ? S + vt[i].re_off : -1,
                        (vt[i].we_off >= 0) ? S + vt[i].we_off : -1,
                        vt[i].addr, vt[i].ewd, vt[i].ewm);
         if (vt[i].cmd == 2'b00) begin
            chk($sformatf("v%0d_rx_busy_s1", i), l_rxb[0][S+1], 1);
            chk($sformatf("v%0d_rx_busy_s9", i), l_rxb[0][S+9], 1);
            chk($sformatf("v%0d_rx_busy_s10", i), l_rxb[0][S+10], 0);
            chk($sformatf("v%0d_tx_busy_s11", i), l_txb[0][S+11], 0);
            chk($sformatf("v%0d_tx_busy_s12", i), l_txb[0][S+12], 1);
            chk($sformatf("v%0d_tx_busy_s21", i), l_txb[0][S+21], 1);
            chk($sformatf("v%0d_tx_busy_s22", i), l_txb[0][S+22], 0);
         end
      end

      // Three back-to-back reads: D=0/1 keep up, D=12 drops the third.
      stim.delete();
      stim.push_back(2'b00);
      stim.push_back(2'b00);
      push_frame(2'b00, 16'h1234, 16'h0000);
      push_frame(2'b00, 16'h0042, 16'h0000);
      push_frame(2'b00, 16'h0777, 16'h0000);
      clear_exp();
      for (int g = 0; g < 2; g++) begin
         add_resp(g, S + 12 + dly(g),      mem_model(16'h1234));
         add_resp(g, S + 22 + dly(g),      mem_model(16'h0042));
         add_resp(g, S + 32 + dly(g),      mem_model(16'h0777));
      end
      add_resp(2, S + 24, mem_model(16'h1234));
      add_resp(2, S + 45, mem_model(16'h0042));
      run(70, -1, -1);
      chk_tx("b2b", 70);
      chk("b2b_ov_g0", l_ov[0][69], 0);
      chk("b2b_ov_g1", l_ov[1][69], 0);
      chk("b2b_ov_g2_s31", l_ov[2][S+31], 0);
      chk("b2b_ov_g2_s32", l_ov[2][S+32], 1);
      chk("b2b_ov_g2_sticky", l_ov[2][69], 1);

      // Reset during payload cycle 4, unarmed hold of 01, then reserved command.
      stim.delete();
      stim.push_back(2'b00);
      stim.push_back(2'b00);
      push_frame(2'b00, 16'h1234, 16'h0000);
      repeat (10) stim.push_back(2'b00);
      repeat (8) stim.push_back(2'b01);
      stim.push_back(2'b00);
      push_frame(2'b11, 16'h5555, 16'h0000);
      clear_exp();
      for (int g = 0; g < NI; g++) begin
         add_resp(g, S + 12 + dly(g), mem_model(16'h1234));
         for (int t = 21; t < MAXC; t++) e_tx[g][t] = 2'b00;
      end
      run(60, 20, 22);
      chk_tx("rst", 60);
      chk("rst_payload4", l_tx[0][20], 2'b10);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_outputs_g%0d", g),
             {l_tx[g][21], l_re[g][21], l_we[g][21], l_addr[g][21], l_wd[g][21], l_wm[g][21],
              l_rxb[g][21], l_txb[g][21], l_ov[g][21], l_bad[g][21]}, 64'd0);
         chk_strobes(g, "rst", 60, S + 10, -1, 16'h1234, 16'h0000, 2'b00);
      end
      begin
         int busy_n;
         busy_n = 0;
         for (int t = 22; t < 32; t++) if (l_rxb[0][t]) busy_n++;
         chk("unarmed_rx_busy", busy_n, 0);
      end
      chk("armed_start", l_rxb[0][32], 1);
      chk("rsvd_rx_busy_end", l_rxb[0][40], 1);
      chk("rsvd_rx_idle", l_rxb[0][41], 0);
      chk("bad_cmd_before", l_bad[0][32], 0);
      chk("bad_cmd_set", l_bad[0][33], 1);
      chk("bad_cmd_sticky", l_bad[0][59], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
